dds_sweep_ctrl: RTL
===================

Name: dds_sweep_ctrl

Overview:
Frequency-sweep scheduler for the DDS phase-accumulator datapath. Drives the 32-bit frequency tuning word (Step) consumed by the sine, triangle and PWM wave generators. Steps the word from a low to a high endpoint in fixed increments, holding each point for a programmable dwell. Supports up, down and triangle sweeps, single-shot or repeating, with start/abort control and busy/done status.

Parameters:
STEP_W, 32, tuning-word width; matches the DDS accumulator step width
DWELL_W, 16, dwell counter width

Ports:
clk  in  1  system clock, single clock domain
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request; accepted only in IDLE
abort  in  1  stop sweep; accepted in any state
mode  in  2  0 up, 1 down, 2 triangle, 3 treated as up
start_step  in  STEP_W  sweep endpoint A
stop_step  in  STEP_W  sweep endpoint B
delta_step  in  STEP_W  increment per point
dwell  in  DWELL_W  cycles per point minus 1
repeat_en  in  1  restart automatically at end of sweep
step_out  out  STEP_W  tuning word to the DDS wave generators
busy  out  1  high while a sweep is active
done  out  1  one-cycle pulse when a non-repeating sweep completes
sweep_dir  out  1  current direction: 1 up, 0 down

Behaviour:
- Reset: step_out=0, busy=0, done=0, sweep_dir=1, state=IDLE, all latched config cleared.
- States: IDLE, DWELL, ADVANCE. Finishing a sweep returns to IDLE with a done pulse; there is no DONE state.
- Config latch: in IDLE with start=1 (cycle N), latch the following:
  - lo=min(start_step,stop_step) and hi=max(start_step,stop_step); endpoints are swapped internally when given in reverse order.
  - delta, with delta_step=0 latched as 1.
  - dwell, mode and repeat_en.
- Config inputs are ignored after the latch at cycle N.
- Sweep start, cycle N+1: busy=1 and state=DWELL.
  - Up or triangle: step_out=lo, sweep_dir=1.
  - Down: step_out=hi, sweep_dir=0.
- DWELL: counter loads 0 on entry and increments each cycle. When it reaches the latched dwell, go to ADVANCE. Each point is therefore visible for exactly dwell+1 cycles, and ADVANCE consumes no visible cycle.
- ADVANCE, combinational decision in the same cycle as the final dwell count:
  - Up direction, step_out<hi: next=min(step_out+delta, hi), computed at STEP_W+1 bits with no wrap.
  - Down direction, step_out>lo: next=max(step_out-delta, lo), computed at STEP_W+1 bits with no wrap.
  - Up at hi in triangle mode: reverse. sweep_dir=0 and next=max(hi-delta, lo).
  - Down at lo in triangle mode: end of sweep.
  - Up at hi in up mode: end of sweep.
  - Down at lo in down mode: end of sweep.
- End of sweep with repeat_en=1: reload the initial value and direction, with no gap cycle and no done pulse.
- End of sweep with repeat_en=0: next cycle done=1 for one cycle, busy=0, state=IDLE. step_out holds its final value.
- lo==hi: a single point held dwell+1 cycles, then done. In triangle mode the direction reverses with no new point.
- start while busy: ignored.
- abort: next cycle state=IDLE, busy=0, done=0, step_out holds its current value.
- abort and start in the same cycle: abort wins, and the start is dropped.
- reset mid-sweep: all outputs return to their reset values on the next clock edge.

Optional Feature:
- Macro DDS_SWEEP_MARKER_EN.
- Defined: adds input marker_step[STEP_W-1:0] and output marker (1 bit). marker pulses for one cycle, coincident with the first cycle a new step_out value is presented, when that value reaches marker_step, for example 110→120 with marker 115:
  - up direction: old<marker_step<=new;
  - down direction: old>marker_step>=new;
  - start point: also pulses if step_out==marker_step.
- Undefined: these ports and their logic are absent.

Decomposition:
- Package dds_sweep_pkg holds:
  - the state enum (IDLE/DWELL/ADVANCE);
  - mode constants MODE_UP=0, MODE_DOWN=1, MODE_TRI=2;
  - STEP_W and DWELL_W defaults.
- One sub-module, dds_dwell_timer: load/enable inputs and an expire output. It is the DWELL_W counter with terminal-count compare.

Test Plan:
- Up sweep. Inputs: mode=0, start_step=100, stop_step=130, delta=10, dwell=2, start at cycle 0. Required: step_out=100 in cycles 1-3, 110 in 4-6, 120 in 7-9, 130 in 10-12. done=1 and busy=0 at cycle 13 only.
- Saturation and swapped endpoints. Inputs: mode=1, start_step=50, stop_step=10, delta=15, dwell=0. Required: step_out sequence 50,35,20,10, one cycle each, then done.
- Triangle repeating. Inputs: mode=2, lo=0, hi=20, delta=10, dwell=0, repeat_en=1. Required: step_out 0,10,20,10,0,0,10,20…, sweep_dir falls on the cycle showing the second 10, done never asserts. Then abort: busy=0 next cycle and step_out frozen.
- Corner cases:
  - delta_step=0 with lo=5, hi=7: step_out 5,6,7 then done.
  - lo==hi=9: one point for dwell+1 cycles, then done.
  - start asserted mid-sweep: no effect.
  - start and abort in the same cycle from IDLE: busy stays 0.
- Marker (DDS_SWEEP_MARKER_EN). Up 100→130, delta 10, dwell=2, marker_step=115. Required: marker pulses exactly once, in cycle 7 when step_out becomes 120.

Source files
------------

// File: rtl/dds_sweep_pkg.sv
// dds_sweep_pkg: shared definitions for the DDS frequency-sweep scheduler.
//   - default widths for the tuning word and the dwell counter
//   - sweep mode encodings (a mode of 3 behaves as an up sweep)
//   - scheduler state encoding, also presented on the fsm_state debug port
package dds_sweep_pkg;

    localparam int DEF_STEP_W  = 32;
    localparam int DEF_DWELL_W = 16;

    localparam logic [1:0] MODE_UP   = 2'd0;
    localparam logic [1:0] MODE_DOWN = 2'd1;
    localparam logic [1:0] MODE_TRI  = 2'd2;

    // ST_ADVANCE is never held in the state register: it marks the final
    // dwell cycle, in which the next point is chosen combinationally.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DWELL   = 2'd1,
        ST_ADVANCE = 2'd2
    } sweep_state_e;

endpackage

// File: rtl/dds_sweep_ctrl_dwell_timer.sv
// dds_dwell_timer: per-point dwell counter with terminal-count compare.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   load       : clear the count to 0 (takes priority over en)
//   en         : count up by one per cycle
//   limit      : terminal count (latched dwell value)
//   expire     : high while enabled and the count equals limit
module dds_dwell_timer #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               en,
    input  logic [DWELL_W-1:0] limit,
    output logic               expire
);

    logic [DWELL_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign expire = en && (count == limit);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: steps the DDS tuning word between two endpoints in fixed
// increments, holding each point for dwell+1 cycles. Up, down and triangle
// sweeps, single-shot or repeating, with start/abort control.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start, abort        : sweep request (IDLE only) / stop (any state, wins)
//   mode                : 0 up, 1 down, 2 triangle, 3 up
//   start_step/stop_step: endpoints, either order
//   delta_step          : increment per point (0 treated as 1)
//   dwell               : cycles per point minus 1
//   repeat_en           : restart at end of sweep instead of finishing
//   step_out            : tuning word to the wave generators
//   busy, done          : sweep active / one-cycle completion pulse
//   sweep_dir           : 1 up, 0 down
//   fsm_state           : debug view of the scheduler state
// Optional (macro DDS_SWEEP_MARKER_EN):
//   marker_step         : marker frequency, latched at start
//   marker              : one-cycle pulse when a new point reaches marker_step
//
// Valid/ready: start is a one-cycle request that is accepted only when the
// block is idle (busy=0) and abort is low; anything else drops it silently.
module dds_sweep_ctrl
    import dds_sweep_pkg::*;
#(
    parameter int STEP_W  = DEF_STEP_W,
    parameter int DWELL_W = DEF_DWELL_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         mode,
    input  logic [STEP_W-1:0]  start_step,
    input  logic [STEP_W-1:0]  stop_step,
    input  logic [STEP_W-1:0]  delta_step,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               repeat_en,
    output logic [STEP_W-1:0]  step_out,
    output logic               busy,
    output logic               done,
    output logic               sweep_dir,
    output logic [1:0]         fsm_state
`ifdef DDS_SWEEP_MARKER_EN
    ,
    input  logic [STEP_W-1:0]  marker_step,
    output logic               marker
`endif
);

    sweep_state_e       state;
    logic [STEP_W-1:0]  lo_q, hi_q, delta_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [1:0]         mode_q;
    logic               repeat_q;
    logic               expire;

    // Endpoint ordering and start values for a fresh start and for a repeat.
    logic [STEP_W-1:0]  in_lo, in_hi, init_step, reload_step;
    logic               init_dir, reload_dir;

    assign in_lo       = (start_step <= stop_step) ? start_step : stop_step;
    assign in_hi       = (start_step <= stop_step) ? stop_step  : start_step;
    assign init_dir    = (mode != MODE_DOWN);
    assign init_step   = init_dir ? in_lo : in_hi;
    assign reload_dir  = (mode_q != MODE_DOWN);
    assign reload_step = reload_dir ? lo_q : hi_q;

    dds_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   ((state == ST_IDLE) || expire),
        .en     (state == ST_DWELL),
        .limit  (dwell_q),
        .expire (expire)
    );

    assign fsm_state = (state == ST_DWELL && expire) ? ST_ADVANCE : state;

    // Next-point decision. Sums/differences are one bit wider so clamping
    // to the endpoints never sees a wrapped value.
    logic [STEP_W:0]   sum, diff;
    logic [STEP_W-1:0] up_sat, dn_sat, nxt_step;
    logic              nxt_dir, move_up, sweep_end;

    always_comb begin
        sum       = {1'b0, step_out} + {1'b0, delta_q};
        diff      = {1'b0, step_out} - {1'b0, delta_q};
        up_sat    = (sum > {1'b0, hi_q}) ? hi_q : sum[STEP_W-1:0];
        dn_sat    = (diff[STEP_W] || (diff[STEP_W-1:0] < lo_q)) ? lo_q : diff[STEP_W-1:0];
        nxt_step  = step_out;
        nxt_dir   = sweep_dir;
        move_up   = sweep_dir;
        sweep_end = 1'b0;
        if (sweep_dir) begin
            if (step_out < hi_q) begin
                nxt_step = up_sat;
            end else if (mode_q == MODE_TRI) begin
                // Turn around at the top; a zero-width range has no second
                // point, so it only flips direction and finishes.
                nxt_dir = 1'b0;
                if (lo_q != hi_q) begin
                    nxt_step = dn_sat;
                    move_up  = 1'b0;
                end else begin
                    sweep_end = 1'b1;
                end
            end else begin
                sweep_end = 1'b1;
            end
        end else begin
            if (step_out > lo_q) begin
                nxt_step = dn_sat;
            end else begin
                sweep_end = 1'b1;
            end
        end
    end

`ifdef DDS_SWEEP_MARKER_EN
    logic [STEP_W-1:0] marker_q;
    logic              step_hit;

    // Crossing test for an advance: old value strictly before the marker,
    // new value at or past it, in the direction of the move.
    assign step_hit = move_up ? ((step_out < marker_q) && (marker_q <= nxt_step))
                              : ((step_out > marker_q) && (marker_q >= nxt_step));
`else
    logic unused_move_up;
    assign unused_move_up = move_up;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            step_out  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sweep_dir <= 1'b1;
            lo_q      <= '0;
            hi_q      <= '0;
            delta_q   <= '0;
            dwell_q   <= '0;
            mode_q    <= MODE_UP;
            repeat_q  <= 1'b0;
`ifdef DDS_SWEEP_MARKER_EN
            marker_q  <= '0;
            marker    <= 1'b0;
`endif
        end else if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef DDS_SWEEP_MARKER_EN
            marker <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef DDS_SWEEP_MARKER_EN
            marker <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        lo_q      <= in_lo;
                        hi_q      <= in_hi;
                        delta_q   <= (delta_step == '0) ? {{(STEP_W-1){1'b0}}, 1'b1} : delta_step;
                        dwell_q   <= dwell;
                        mode_q    <= mode;
                        repeat_q  <= repeat_en;
                        step_out  <= init_step;
                        sweep_dir <= init_dir;
                        busy      <= 1'b1;
                        state     <= ST_DWELL;
`ifdef DDS_SWEEP_MARKER_EN
                        marker_q  <= marker_step;
                        marker    <= (init_step == marker_step);
`endif
                    end
                end
                ST_DWELL: begin
                    if (expire) begin
                        if (!sweep_end) begin
                            step_out  <= nxt_step;
                            sweep_dir <= nxt_dir;
`ifdef DDS_SWEEP_MARKER_EN
                            marker    <= step_hit;
`endif
                        end else if (repeat_q) begin
                            step_out  <= reload_step;
                            sweep_dir <= reload_dir;
`ifdef DDS_SWEEP_MARKER_EN
                            marker    <= (reload_step == marker_q);
`endif
                        end else begin
                            sweep_dir <= nxt_dir;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
